// File: rtl/fwd_pkg.sv
// Shared types for the dual-pipe forwarding/hazard controller: forwarding mode
// encoding, per-stage destination tag and the operand match helper.
package fwd_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_STAGES = 3;

  localparam int STAGE_EX  = 0;
  localparam int STAGE_MEM = 1;
  localparam int STAGE_WB  = 2;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    FWD_NONE    = 3'd0,
    FWD_BR_EX   = 3'd1,
    FWD_MEM_EX  = 3'd2,
    FWD_BR_MEM  = 3'd3,
    FWD_MEM_MEM = 3'd4,
    FWD_BR_WB   = 3'd5,
    FWD_MEM_WB  = 3'd6
  } fwd_mode_e;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [REG_ADDR_W-1:0] rd;
    logic                  is_load;
  } fwd_tag_t;

  // x0 is hardwired, so a producer writing it never forwards.
  function automatic logic tag_hit(input fwd_tag_t t, input logic [REG_ADDR_W-1:0] rs);
    return t.valid && t.we && (t.rd == rs) && (rs != REG_ZERO);
  endfunction

endpackage

// File: rtl/forwarding_control_unit_if.sv
// ID-bundle / forwarding-result bus between the issue logic (master) and the
// forwarding controller (slave). Perf outputs exist only with FWD_PERF_CNT_EN.
interface forwarding_control_unit_if;
  import fwd_pkg::*;

  // id_valid qualifies the ID bundle; there is no ready. The producer holds the
  // bundle stable while lu_stall or ext_stall is high, and the bundle is taken on
  // a clock edge with id_valid && !lu_stall && !ext_stall && !flush.
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_br_rs1;
  logic [REG_ADDR_W-1:0] id_br_rs2;
  logic [REG_ADDR_W-1:0] id_mem_rs1;
  logic [REG_ADDR_W-1:0] id_mem_rs2;
  logic [REG_ADDR_W-1:0] id_br_rd;
  logic                  id_br_we;
  logic [REG_ADDR_W-1:0] id_mem_rd;
  logic                  id_mem_we;
  logic                  id_mem_load;
  logic                  ext_stall;
  logic                  flush;

  fwd_mode_e             fwd_br_rs1;
  fwd_mode_e             fwd_br_rs2;
  fwd_mode_e             fwd_mem_rs1;
  fwd_mode_e             fwd_mem_rs2;
  logic                  lu_stall;

`ifdef FWD_PERF_CNT_EN
  logic [31:0]           perf_lu_stalls;
  logic [31:0]           perf_fwd_events;

  modport master (
    output id_valid, id_br_rs1, id_br_rs2, id_mem_rs1, id_mem_rs2,
           id_br_rd, id_br_we, id_mem_rd, id_mem_we, id_mem_load, ext_stall, flush,
    input  fwd_br_rs1, fwd_br_rs2, fwd_mem_rs1, fwd_mem_rs2, lu_stall,
           perf_lu_stalls, perf_fwd_events
  );

  modport slave (
    input  id_valid, id_br_rs1, id_br_rs2, id_mem_rs1, id_mem_rs2,
           id_br_rd, id_br_we, id_mem_rd, id_mem_we, id_mem_load, ext_stall, flush,
    output fwd_br_rs1, fwd_br_rs2, fwd_mem_rs1, fwd_mem_rs2, lu_stall,
           perf_lu_stalls, perf_fwd_events
  );
`else
  modport master (
    output id_valid, id_br_rs1, id_br_rs2, id_mem_rs1, id_mem_rs2,
           id_br_rd, id_br_we, id_mem_rd, id_mem_we, id_mem_load, ext_stall, flush,
    input  fwd_br_rs1, fwd_br_rs2, fwd_mem_rs1, fwd_mem_rs2, lu_stall
  );

  modport slave (
    input  id_valid, id_br_rs1, id_br_rs2, id_mem_rs1, id_mem_rs2,
           id_br_rd, id_br_we, id_mem_rd, id_mem_we, id_mem_load, ext_stall, flush,
    output fwd_br_rs1, fwd_br_rs2, fwd_mem_rs1, fwd_mem_rs2, lu_stall
  );
`endif

endinterface

// File: rtl/fwd_operand_sel.sv
// Per-operand forwarding source select: youngest stage first, and within a
// stage the Memory pipe (program-order younger) beats the Branch pipe.
module fwd_operand_sel
  import fwd_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs,
  input  fwd_tag_t              ex_br,
  input  fwd_tag_t              ex_mem,
  input  fwd_tag_t              mem_br,
  input  fwd_tag_t              mem_mem,
  input  fwd_tag_t              wb_br,
  input  fwd_tag_t              wb_mem,
  output fwd_mode_e             mode,
  output logic                  src_load
);

  // src_load reports whether the winning producer is a load; the top uses it
  // to spot load-use hazards against the Memory EX slot.
  always_comb begin
    mode     = FWD_NONE;
    src_load = 1'b0;
    if (tag_hit(ex_mem, rs)) begin
      mode     = FWD_MEM_EX;
      src_load = ex_mem.is_load;
    end else if (tag_hit(ex_br, rs)) begin
      mode     = FWD_BR_EX;
      src_load = ex_br.is_load;
    end else if (tag_hit(mem_mem, rs)) begin
      mode     = FWD_MEM_MEM;
      src_load = mem_mem.is_load;
    end else if (tag_hit(mem_br, rs)) begin
      mode     = FWD_BR_MEM;
      src_load = mem_br.is_load;
    end else if (tag_hit(wb_mem, rs)) begin
      mode     = FWD_MEM_WB;
      src_load = wb_mem.is_load;
    end else if (tag_hit(wb_br, rs)) begin
      mode     = FWD_BR_WB;
      src_load = wb_br.is_load;
    end
  end

endmodule

// File: rtl/forwarding_control_unit.sv
// Dual-pipe forwarding and load-use hazard controller. Define FWD_PERF_CNT_EN
// to add the saturating perf_lu_stalls / perf_fwd_events counters.
module forwarding_control_unit
  import fwd_pkg::*;
(
  input logic                       clk,
  input logic                       rst,
  forwarding_control_unit_if.slave  bus
);

  localparam int NUM_OPS = 4;

  fwd_tag_t              br_tag  [NUM_STAGES];
  fwd_tag_t              mem_tag [NUM_STAGES];
  logic [REG_ADDR_W-1:0] op_rs   [NUM_OPS];
  fwd_mode_e             op_mode [NUM_OPS];
  logic                  op_load [NUM_OPS];
  fwd_mode_e             fwd_q   [NUM_OPS];
  logic                  lu_hit;
  logic                  lu_stall;
  logic                  take_id;

  assign op_rs[0] = bus.id_br_rs1;
  assign op_rs[1] = bus.id_br_rs2;
  assign op_rs[2] = bus.id_mem_rs1;
  assign op_rs[3] = bus.id_mem_rs2;

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    fwd_operand_sel u_sel (
      .rs       (op_rs[i]),
      .ex_br    (br_tag[STAGE_EX]),
      .ex_mem   (mem_tag[STAGE_EX]),
      .mem_br   (br_tag[STAGE_MEM]),
      .mem_mem  (mem_tag[STAGE_MEM]),
      .wb_br    (br_tag[STAGE_WB]),
      .wb_mem   (mem_tag[STAGE_WB]),
      .mode     (op_mode[i]),
      .src_load (op_load[i])
    );
  end

  // Memory EX always wins priority, so a load there is the selected source
  // whenever any operand depends on it.
  always_comb begin
    lu_hit = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (op_mode[i] == FWD_MEM_EX && op_load[i]) lu_hit = 1'b1;
    end
  end

  assign lu_stall     = bus.id_valid && !bus.flush && lu_hit;
  assign take_id      = bus.id_valid && !bus.flush && !lu_stall;
  assign bus.lu_stall = lu_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_STAGES; s++) begin
        br_tag[s]  <= '0;
        mem_tag[s] <= '0;
      end
      for (int i = 0; i < NUM_OPS; i++) fwd_q[i] <= FWD_NONE;
    end else if (!bus.ext_stall) begin
      for (int s = 1; s < NUM_STAGES; s++) begin
        br_tag[s]  <= br_tag[s-1];
        mem_tag[s] <= mem_tag[s-1];
      end
      if (take_id) begin
        br_tag[STAGE_EX]  <= '{valid: 1'b1, we: bus.id_br_we, rd: bus.id_br_rd, is_load: 1'b0};
        mem_tag[STAGE_EX] <= '{valid: 1'b1, we: bus.id_mem_we, rd: bus.id_mem_rd,
                               is_load: bus.id_mem_load};
        for (int i = 0; i < NUM_OPS; i++) fwd_q[i] <= op_mode[i];
      end else begin
        // Bubble: idle ID, load-use hold, or flush.
        br_tag[STAGE_EX]  <= '0;
        mem_tag[STAGE_EX] <= '0;
        for (int i = 0; i < NUM_OPS; i++) fwd_q[i] <= FWD_NONE;
      end
    end
  end

  assign bus.fwd_br_rs1  = fwd_q[0];
  assign bus.fwd_br_rs2  = fwd_q[1];
  assign bus.fwd_mem_rs1 = fwd_q[2];
  assign bus.fwd_mem_rs2 = fwd_q[3];

`ifdef FWD_PERF_CNT_EN
  logic [31:0] lu_cnt;
  logic [31:0] ev_cnt;
  logic [2:0]  ev_inc;

  always_comb begin
    ev_inc = 3'd0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (fwd_q[i] != FWD_NONE) ev_inc = ev_inc + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_cnt <= '0;
      ev_cnt <= '0;
    end else begin
      if (lu_stall && lu_cnt != 32'hFFFF_FFFF) lu_cnt <= lu_cnt + 32'd1;
      if (br_tag[STAGE_EX].valid && !bus.ext_stall && ev_inc != 3'd0) begin
        if (ev_cnt > 32'hFFFF_FFFF - {29'd0, ev_inc}) ev_cnt <= 32'hFFFF_FFFF;
        else                                          ev_cnt <= ev_cnt + {29'd0, ev_inc};
      end
    end
  end

  assign bus.perf_lu_stalls  = lu_cnt;
  assign bus.perf_fwd_events = ev_cnt;
`endif

endmodule
